// File: rtl/icache_axi_rd_bridge.sv
// I-cache refill bridge: turns a level-held refill request into a single-beat
// AXI4 read and returns one 32-bit instruction word with a completion pulse.
module icache_axi_rd_bridge #(
    parameter logic [3:0]  AXI_ID        = 4'h0,
    parameter int unsigned ADDR_MASK_LSB = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cache_read_ena,
    input  logic [63:0] cache_addr,
    output logic [31:0] cache_or_data,
    output logic        cache_in_ok,
    output logic        rd_err,
    output logic        ar_valid,
    input  logic        ar_ready,
    output logic [63:0] ar_addr,
    output logic [3:0]  ar_id,
    output logic [7:0]  ar_len,
    output logic [2:0]  ar_size,
    output logic [1:0]  ar_burst,
    input  logic        r_valid,
    output logic        r_ready,
    input  logic [63:0] r_data,
    input  logic [1:0]  r_resp,
    input  logic        r_last,
    input  logic [3:0]  r_id,
    output logic [31:0] refill_cnt,
    output logic [2:0]  dbg_state,
    output logic        dbg_r_last
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never drops and its payload never changes until then.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_RESP = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    localparam logic [63:0] ADDR_MASK = ~((64'd1 << ADDR_MASK_LSB) - 64'd1);

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] refill_cnt_q, refill_cnt_d;
    logic        abort_q, abort_d;
    logic        ar_valid_q, ar_valid_d;
    logic        r_ready_q, r_ready_d;
    logic        cache_in_ok_q, cache_in_ok_d;
    logic        rd_err_q, rd_err_d;
    logic        last_q, last_d;
    logic        beat_match;

    assign beat_match = r_valid && r_ready_q && (r_id == AXI_ID);

    // Next-state and next-output computation for the refill sequence.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        data_d        = data_q;
        refill_cnt_d  = refill_cnt_q;
        abort_d       = abort_q;
        ar_valid_d    = ar_valid_q;
        r_ready_d     = r_ready_q;
        cache_in_ok_d = 1'b0;
        rd_err_d      = 1'b0;
        last_d        = last_q;
        case (state_q)
            S_IDLE: begin
                if (cache_read_ena) begin
                    addr_d     = cache_addr;
                    abort_d    = 1'b0;
                    ar_valid_d = 1'b1;
                    state_d    = S_ADDR;
                end
            end
            S_ADDR: begin
                // A dropped request still finishes the bus transaction.
                if (!cache_read_ena) abort_d = 1'b1;
                if (ar_valid_q && ar_ready) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (!cache_read_ena) abort_d = 1'b1;
                // Beats with a foreign ID are accepted and dropped here.
                if (beat_match) begin
                    r_ready_d = 1'b0;
                    last_d    = r_last;
                    if (abort_q || !cache_read_ena) begin
                        state_d = S_IDLE;
                    end else begin
                        data_d        = addr_q[2] ? r_data[63:32] : r_data[31:0];
                        cache_in_ok_d = 1'b1;
                        rd_err_d      = (r_resp != 2'b00);
                        state_d       = S_RESP;
                    end
                end
            end
            S_RESP: begin
                refill_cnt_d = refill_cnt_q + 32'd1;
                state_d      = S_HOLD;
            end
            S_HOLD: begin
                // Wait for the cache to release the request so it is not re-issued.
                if (!cache_read_ena) state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                ar_valid_d = 1'b0;
                r_ready_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            addr_q        <= 64'h0;
            data_q        <= 32'h0;
            refill_cnt_q  <= 32'h0;
            abort_q       <= 1'b0;
            ar_valid_q    <= 1'b0;
            r_ready_q     <= 1'b0;
            cache_in_ok_q <= 1'b0;
            rd_err_q      <= 1'b0;
            last_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            refill_cnt_q  <= refill_cnt_d;
            abort_q       <= abort_d;
            ar_valid_q    <= ar_valid_d;
            r_ready_q     <= r_ready_d;
            cache_in_ok_q <= cache_in_ok_d;
            rd_err_q      <= rd_err_d;
            last_q        <= last_d;
        end
    end

    assign ar_valid      = ar_valid_q;
    assign ar_addr       = addr_q & ADDR_MASK;
    assign ar_id         = AXI_ID;
    assign ar_len        = 8'd0;
    assign ar_size       = 3'b010;
    assign ar_burst      = 2'b01;
    assign r_ready       = r_ready_q;
    assign cache_or_data = data_q;
    assign cache_in_ok   = cache_in_ok_q;
    assign rd_err        = rd_err_q;
    assign refill_cnt    = refill_cnt_q;
    assign dbg_state     = state_q;
    assign dbg_r_last    = last_q;

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Directed bench for the I-cache AXI read bridge.
module tb_icache_axi_rd_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cache_read_ena;
    logic [63:0] cache_addr;
    logic [31:0] cache_or_data;
    logic        cache_in_ok;
    logic        rd_err;
    logic        ar_valid;
    logic        ar_ready;
    logic [63:0] ar_addr;
    logic [3:0]  ar_id;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid;
    logic        r_ready;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [3:0]  r_id;
    logic [31:0] refill_cnt;
    logic [2:0]  dbg_state;
    logic        dbg_r_last;

    int checks = 0;
    int errors = 0;
    int ar_hs_cnt = 0;
    int ok_cnt = 0;

    icache_axi_rd_bridge dut (
        .clk(clk), .rst(rst),
        .cache_read_ena(cache_read_ena), .cache_addr(cache_addr),
        .cache_or_data(cache_or_data), .cache_in_ok(cache_in_ok), .rd_err(rd_err),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .r_last(r_last), .r_id(r_id),
        .refill_cnt(refill_cnt), .dbg_state(dbg_state), .dbg_r_last(dbg_r_last)
    );

    always #5 clk = ~clk;

    // Count address handshakes and completion pulses seen on the bus.
    always @(posedge clk) begin
        if (ar_valid && ar_ready) ar_hs_cnt <= ar_hs_cnt + 1;
        if (cache_in_ok) ok_cnt <= ok_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_refill(input string tag, input logic [63:0] addr, input int ar_wait,
                              input logic [63:0] rdata, input logic [1:0] rresp,
                              input logic rlast, input bit bad_first, input int hold_cyc,
                              input logic [31:0] exp_data, input logic exp_err,
                              input logic [31:0] exp_cnt);
        logic [63:0] exp_ar;
        int arv_cnt;
        int hs0;
        int ok0;
        exp_ar = {addr[63:2], 2'b00};
        hs0 = ar_hs_cnt;
        ok0 = ok_cnt;
        cache_read_ena = 1'b1;
        cache_addr = addr;
        tick();
        cache_addr = ~addr;
        check({tag, "_ar_addr"}, ar_addr, exp_ar);
        arv_cnt = 0;
        for (int i = 0; i < ar_wait; i++) begin
            if (ar_valid && ar_addr == exp_ar) arv_cnt++;
            tick();
        end
        if (ar_valid && ar_addr == exp_ar) arv_cnt++;
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        check({tag, "_arv_cycles"}, 64'(arv_cnt), 64'(ar_wait + 1));
        check({tag, "_ar_done"}, {63'h0, ar_valid}, 64'h0);
        check({tag, "_r_ready"}, {63'h0, r_ready}, 64'h1);
        tick();
        if (bad_first) begin
            r_valid = 1'b1; r_id = 4'h3; r_data = ~rdata; r_resp = 2'b00; r_last = 1'b1;
            tick();
            check({tag, "_bad_beat_state"}, {61'h0, dbg_state}, 64'd2);
        end
        r_valid = 1'b1; r_id = 4'h0; r_data = rdata; r_resp = rresp; r_last = rlast;
        tick();
        r_valid = 1'b0; r_data = 64'h0; r_resp = 2'b00; r_last = 1'b0;
        check({tag, "_ok"}, {63'h0, cache_in_ok}, 64'h1);
        check({tag, "_no_early_ok"}, 64'(ok_cnt), 64'(ok0));
        check({tag, "_data"}, {32'h0, cache_or_data}, {32'h0, exp_data});
        check({tag, "_err"}, {63'h0, rd_err}, {63'h0, exp_err});
        for (int i = 0; i < hold_cyc; i++) begin
            tick();
            check({tag, "_hold_ok"}, {62'h0, cache_in_ok, rd_err}, 64'h0);
            check({tag, "_hold_state"}, {61'h0, dbg_state}, 64'd4);
            check({tag, "_hold_data"}, {32'h0, cache_or_data}, {32'h0, exp_data});
        end
        check({tag, "_cnt"}, {32'h0, refill_cnt}, {32'h0, exp_cnt});
        cache_read_ena = 1'b0;
        tick();
        check({tag, "_idle"}, {61'h0, dbg_state}, 64'd0);
        check({tag, "_one_ar"}, 64'(ar_hs_cnt), 64'(hs0 + 1));
        check({tag, "_one_ok"}, 64'(ok_cnt), 64'(ok0 + 1));
    endtask

    initial begin
        rst = 1'b1;
        cache_read_ena = 1'b0; cache_addr = 64'h0; ar_ready = 1'b0;
        r_valid = 1'b0; r_data = 64'h0; r_resp = 2'b00; r_last = 1'b0; r_id = 4'h0;
        tick();
        tick();
        check("rst_outputs", {ar_valid, r_ready, cache_in_ok, rd_err, dbg_state}, 64'h0);
        check("rst_data_cnt", {cache_or_data, refill_cnt}, 64'h0);
        rst = 1'b0;
        tick();
        check("ar_fixed", {44'h0, ar_id, ar_len, ar_size, ar_burst}, {44'h0, 4'h0, 8'd0, 3'b010, 2'b01});

        run_refill("t1", 64'h8000_0004, 0, 64'h1234_5678_9ABC_DEF0, 2'b00, 1'b1, 1'b0, 3,
                   32'h1234_5678, 1'b0, 32'd1);
        run_refill("t2", 64'h8000_0000, 5, 64'h1234_5678_9ABC_DEF0, 2'b00, 1'b1, 1'b0, 1,
                   32'h9ABC_DEF0, 1'b0, 32'd2);
        run_refill("t3_slverr", 64'h8000_0008, 0, 64'hCAFE_BABE_DEAD_BEEF, 2'b10, 1'b0, 1'b0, 1,
                   32'hDEAD_BEEF, 1'b1, 32'd3);
        run_refill("t4_badid", 64'h8000_000F, 2, 64'h1111_2222_3333_4444, 2'b00, 1'b1, 1'b1, 2,
                   32'h1111_2222, 1'b0, 32'd4);

        // Request withdrawn mid-transaction: bus completes, result discarded.
        cache_read_ena = 1'b1; cache_addr = 64'h8000_0010;
        tick();
        cache_read_ena = 1'b0;
        tick();
        check("abort_ar_held", {63'h0, ar_valid}, 64'h1);
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        check("abort_in_data", {61'h0, dbg_state}, 64'd2);
        r_valid = 1'b1; r_id = 4'h0; r_data = 64'h5555_6666_7777_8888; r_last = 1'b1;
        tick();
        r_valid = 1'b0;
        check("abort_idle", {61'h0, dbg_state}, 64'd0);
        check("abort_no_ok", {63'h0, cache_in_ok}, 64'h0);
        check("abort_data", {32'h0, cache_or_data}, 64'h1111_2222);
        tick();
        check("abort_cnt", {32'h0, refill_cnt}, 64'd4);
        check("abort_ok_cnt", 64'(ok_cnt), 64'd4);

        // Reset while waiting for data clears everything at once.
        cache_read_ena = 1'b1; cache_addr = 64'h8000_0020;
        tick();
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        check("pre_rst_data", {61'h0, dbg_state}, 64'd2);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ctrl", {ar_valid, r_ready, cache_in_ok, rd_err, dbg_state}, 64'h0);
        check("mid_rst_data_cnt", {cache_or_data, refill_cnt}, 64'h0);
        check("mid_rst_addr", ar_addr, 64'h0);
        cache_read_ena = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle", {61'h0, dbg_state}, 64'd0);

        // Counter wrap from all ones.
        dut.refill_cnt_q = 32'hFFFF_FFFF;
        #1;
        check("preset_cnt", {32'h0, refill_cnt}, 64'hFFFF_FFFF);
        run_refill("t5_wrap", 64'h8000_0004, 0, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 1'b1, 1'b0, 1,
                   32'hAAAA_BBBB, 1'b0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_axi_rd_bridge.md
ICACHE_AXI_RD_BRIDGE -- requirements
Module: icache_axi_rd_bridge

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'h0, ID driven on every AR beat.
REQ-002 SHALL have parameter ADDR_MASK_LSB, default 2, number of low address bits forced to zero on ar_addr.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cache_read_ena  input  1  I-cache refill request level, held high until cache_in_ok seen.
REQ-006 cache_addr  input  64  instruction fetch address of the refill.
REQ-007 cache_or_data  output  32  instruction word returned to I-cache.
REQ-008 cache_in_ok  output  1  one-cycle pulse, cache_or_data valid.
REQ-009 rd_err  output  1  one-cycle pulse coincident with cache_in_ok when response was not OKAY.
REQ-010 ar_valid/ar_ready  output/input  1/1  AXI4 read-address handshake.
REQ-011 ar_addr  output  64;  ar_id  output  4;  ar_len  output  8;  ar_size  output  3;  ar_burst  output  2.
REQ-012 r_valid/r_ready  input/output  1/1  AXI4 read-data handshake.
REQ-013 r_data  input  64;  r_resp  input  2;  r_last  input  1;  r_id  input  4.
REQ-014 refill_cnt  output  32  count of completed refills.

Function
REQ-015 SHALL implement FSM states IDLE, ADDR, DATA, RESP, HOLD.
REQ-016 IDLE: cache_read_ena=1 -> latch cache_addr into addr_q, go ADDR next cycle; else stay.
REQ-017 ADDR: ar_valid=1; ar_addr={addr_q[63:2],2'b00}; ar_len=8'd0; ar_size=3'b010; ar_burst=2'b01; ar_id=AXI_ID; ar_* stable until ar_ready.
REQ-018 ADDR: ar_valid&ar_ready -> DATA; ar_valid SHALL not drop before handshake.
REQ-019 DATA: r_ready=1; on r_valid&r_ready with r_id==AXI_ID, capture r_data[63:32] if addr_q[2]=1 else r_data[31:0] into data_q, capture resp_err=(r_resp!=2'b00), go RESP.
REQ-020 DATA: beat with r_id!=AXI_ID SHALL be accepted (r_ready=1) and discarded, state unchanged.
REQ-021 DATA: r_last=0 on matching beat SHALL still complete the refill (single-beat contract); later beats discarded in HOLD/IDLE via r_ready=1 only in DATA (no acceptance outside DATA).
REQ-022 RESP: cache_in_ok=1, cache_or_data=data_q, rd_err=resp_err for exactly one cycle; refill_cnt+1 (wraps 32'hFFFF_FFFF -> 0); go HOLD.
REQ-023 HOLD: wait until cache_read_ena=0, then IDLE; prevents re-issue of the same refill.
REQ-024 cache_or_data SHALL hold data_q after RESP until next capture; cache_in_ok=0 outside RESP.
REQ-025 Latency: request in IDLE to cache_in_ok = 3 cycles + AR wait + R wait; minimum 4 cycles with ar_ready=1 and r_valid one cycle after AR.
REQ-026 cache_addr changes after latch SHALL be ignored until next IDLE.
REQ-027 cache_read_ena dropping in ADDR/DATA SHALL not abort the AXI transaction; result discarded: RESP skipped (no cache_in_ok, no count), go IDLE.
REQ-028 ar_valid and r_ready SHALL be registered outputs (no combinational path from ar_ready/r_valid).

Reset
REQ-029 rst=1 SHALL immediately force IDLE, ar_valid=0, r_ready=0, cache_in_ok=0, rd_err=0, cache_or_data=32'h0, refill_cnt=0, addr_q=0.
REQ-030 Reset mid-transaction SHALL abandon it; bus-side cleanup is the interconnect's responsibility.

Verification
REQ-031 cache_addr=64'h8000_0004, ar_ready=1, r_data=64'h1234_5678_9ABC_DEF0 OKAY one cycle after AR -> ar_addr=64'h8000_0004, cache_or_data=32'h1234_5678, cache_in_ok one pulse 4 cycles after request, refill_cnt=1.
REQ-032 cache_addr=64'h8000_0000, ar_ready delayed 5 cycles -> ar_valid held 6 cycles with stable ar_addr, cache_or_data=32'h9ABC_DEF0.
REQ-033 r_resp=2'b10 -> cache_in_ok and rd_err pulse together, refill_cnt increments.
REQ-034 r_id=4'h3 beat before matching beat -> first discarded, data from matching beat only.
REQ-035 cache_read_ena held high 3 cycles after cache_in_ok -> stays HOLD, exactly one AR issued; drop ena -> IDLE.
REQ-036 rst asserted in DATA -> all outputs to reset values same cycle; refill_cnt preset 32'hFFFF_FFFF then one refill -> 0.
